// File: rtl/count_cycle_sched_pkg.sv
// rtl/count_cycle_sched_pkg.sv - shared state encoding and constants for the frame-length scheduler
package count_cycle_sched_pkg;

   // Width of the counter's cnt_limit and of the frame beat counter
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_APPLY = 2'd3
   } sched_state_t;

   // All-ones value of the in-flight beat counter for a given width
   function automatic int unsigned outs_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/count_cycle_sched.sv
// rtl/count_cycle_sched.sv - applies new frame lengths to a cycle counter only at drained frame boundaries
module count_cycle_sched
   import count_cycle_sched_pkg::*;
#(
   parameter int               DATA_WIDTH    = 32,
   parameter logic [CNT_W-1:0] DEFAULT_LIMIT = 16'd255,
   parameter int               RST_CYCLES    = 2,
   parameter int               OUTS_WIDTH    = 5
) (
   input  logic                  clk,
   input  logic                  sync_reset_n,
   input  logic                  cfg_tvalid,
   input  logic [CNT_W-1:0]      cfg_tdata,
   output logic                  cfg_tready,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  s_axis_tready,
   output logic                  c_axis_tvalid,
   output logic [DATA_WIDTH-1:0] c_axis_tdata,
   input  logic                  c_axis_tready,
   output logic [CNT_W-1:0]      cnt_limit,
   output logic                  cnt_sync_reset,
   input  logic                  mon_tvalid,
   input  logic                  mon_tready,
   input  logic                  mon_final_cnt,
   output logic                  limit_applied,
   output logic                  busy,
   output logic                  mon_err
);

   localparam int                    RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]       RC_INIT  = RC_W'(RST_CYCLES - 1);
   localparam logic [OUTS_WIDTH-1:0] OUTS_MAX = OUTS_WIDTH'(outs_max(OUTS_WIDTH));
   localparam logic [OUTS_WIDTH-1:0] OUTS_ONE = OUTS_WIDTH'(1);

   sched_state_t          state_q;
   logic [RC_W-1:0]       rst_cnt_q;
   logic [CNT_W-1:0]      cnt_limit_q;
   logic                  pending_q;
   logic [CNT_W-1:0]      pending_val_q;
   logic [CNT_W-1:0]      beat_cnt_q;
   logic                  limit_applied_q;
   logic                  mon_err_q;
   logic [OUTS_WIDTH-1:0] outs_q;
   logic [OUTS_WIDTH-1:0] outs_d;
   logic                  outs_err;
   logic                  final_err;
   logic                  run_en;
   logic                  accept;
   logic                  mon_hs;
   logic                  cfg_hs;

   // Zero-latency pass-through, open only in RUN and never while reset is asserted
   assign run_en        = (state_q == ST_RUN) & sync_reset_n;
   assign c_axis_tvalid = run_en & s_axis_tvalid;
   assign s_axis_tready = run_en & c_axis_tready;
   assign c_axis_tdata  = s_axis_tdata;
   assign accept        = c_axis_tvalid & c_axis_tready;
   assign mon_hs        = mon_tvalid & mon_tready;

   assign cfg_tready     = ~pending_q & (state_q != ST_RST) & sync_reset_n;
   assign cfg_hs         = cfg_tvalid & cfg_tready;
   assign cnt_sync_reset = ~sync_reset_n | (state_q == ST_RST) | (state_q == ST_APPLY);
   assign busy           = (state_q != ST_RUN);
   assign cnt_limit      = cnt_limit_q;
   assign limit_applied  = limit_applied_q;
   assign mon_err        = mon_err_q;

   // The beat leaving the counter while draining the last in-flight beat must close the frame
   assign final_err = (state_q == ST_DRAIN) & mon_hs & (outs_q == OUTS_ONE) & ~mon_final_cnt;

   // In-flight beat count between our accept and the counter output, saturating at both ends
   always_comb begin
      outs_d   = outs_q;
      outs_err = 1'b0;
      if (accept && !mon_hs) begin
         if (outs_q == OUTS_MAX) outs_err = 1'b1;
         else                    outs_d   = outs_q + OUTS_ONE;
      end else if (mon_hs && !accept) begin
         if (outs_q == '0) outs_err = 1'b1;
         else              outs_d   = outs_q - OUTS_ONE;
      end
   end

   // In-flight counter register and sticky monitor error
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         outs_q    <= '0;
         mon_err_q <= 1'b0;
      end else begin
         outs_q <= outs_d;
         if (outs_err || final_err) mon_err_q <= 1'b1;
      end
   end

   // Scheduler FSM: frame tracking, config staging and limit hand-over under counter reset
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state_q         <= ST_RST;
         rst_cnt_q       <= RC_INIT;
         cnt_limit_q     <= DEFAULT_LIMIT;
         pending_q       <= 1'b0;
         pending_val_q   <= '0;
         beat_cnt_q      <= DEFAULT_LIMIT;
         limit_applied_q <= 1'b0;
      end else begin
         limit_applied_q <= 1'b0;
         if (cfg_hs) begin
            pending_q     <= 1'b1;
            pending_val_q <= cfg_tdata;
         end
         case (state_q)
            ST_RST: begin
               if (rst_cnt_q == '0) state_q   <= ST_RUN;
               else                 rst_cnt_q <= rst_cnt_q - 1'b1;
            end
            ST_RUN: begin
               if (accept) begin
                  if (beat_cnt_q == '0) begin
                     beat_cnt_q <= cnt_limit_q;
                     if (pending_q) state_q <= ST_DRAIN;
                  end else begin
                     beat_cnt_q <= beat_cnt_q - 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (outs_q == '0 && !accept) begin
                  state_q   <= ST_APPLY;
                  rst_cnt_q <= RC_INIT;
               end
            end
            ST_APPLY: begin
               // First APPLY cycle is recognised by the freshly loaded hold counter
               if (rst_cnt_q == RC_INIT) begin
                  cnt_limit_q <= pending_val_q;
                  pending_q   <= 1'b0;
               end
               if (rst_cnt_q == '0) begin
                  state_q         <= ST_RUN;
                  beat_cnt_q      <= (rst_cnt_q == RC_INIT) ? pending_val_q : cnt_limit_q;
                  limit_applied_q <= 1'b1;
               end else begin
                  rst_cnt_q <= rst_cnt_q - 1'b1;
               end
            end
            default: state_q <= ST_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_count_cycle_sched.sv
// tb/tb_count_cycle_sched.sv - directed self-checking bench for count_cycle_sched
`timescale 1ns/1ps
module tb_count_cycle_sched;

   logic        clk = 1'b0;
   logic        sync_reset_n;
   logic        cfg_tvalid;
   logic [15:0] cfg_tdata;
   logic        cfg_tready;
   logic        s_axis_tvalid;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tready;
   logic        c_axis_tvalid;
   logic [31:0] c_axis_tdata;
   logic        c_axis_tready;
   logic [15:0] cnt_limit;
   logic        cnt_sync_reset;
   logic        mon_tvalid;
   logic        mon_tready;
   logic        mon_final_cnt;
   logic        limit_applied;
   logic        busy;
   logic        mon_err;

   int   checks  = 0;
   int   errors  = 0;
   int   acc_cnt = 0;
   int   mdl_pos = 0;
   logic mdl_q[$];
   logic mdl_vld = 1'b0;
   logic mdl_fin = 1'b0;
   logic last_cfg_hs = 1'b0;
   logic force_mon = 1'b0;
   logic mon_rdy = 1'b1;

   assign mon_tvalid    = force_mon | mdl_vld;
   assign mon_tready    = mon_rdy;
   assign mon_final_cnt = mdl_fin;

   count_cycle_sched dut (
      .clk            (clk),
      .sync_reset_n   (sync_reset_n),
      .cfg_tvalid     (cfg_tvalid),
      .cfg_tdata      (cfg_tdata),
      .cfg_tready     (cfg_tready),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tready  (s_axis_tready),
      .c_axis_tvalid  (c_axis_tvalid),
      .c_axis_tdata   (c_axis_tdata),
      .c_axis_tready  (c_axis_tready),
      .cnt_limit      (cnt_limit),
      .cnt_sync_reset (cnt_sync_reset),
      .mon_tvalid     (mon_tvalid),
      .mon_tready     (mon_tready),
      .mon_final_cnt  (mon_final_cnt),
      .limit_applied  (limit_applied),
      .busy           (busy),
      .mon_err        (mon_err)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the downstream counter: one-beat pipe that flags every frame's last beat
   always @(posedge clk) begin
      logic acc;
      logic mhs;
      acc = c_axis_tvalid & c_axis_tready;
      mhs = mon_tvalid & mon_tready;
      last_cfg_hs = cfg_tvalid & cfg_tready;
      if (acc) acc_cnt++;
      if (cnt_sync_reset) begin
         mdl_q.delete();
         mdl_pos = int'(cnt_limit);
      end else begin
         if (mhs && mdl_q.size() > 0) void'(mdl_q.pop_front());
         if (acc) begin
            mdl_q.push_back(mdl_pos == 0);
            mdl_pos = (mdl_pos == 0) ? int'(cnt_limit) : mdl_pos - 1;
         end
      end
      #1;
      mdl_vld = (mdl_q.size() > 0);
      mdl_fin = (mdl_q.size() > 0) ? mdl_q[0] : 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (cfg_tvalid && last_cfg_hs) cfg_tvalid = 1'b0;
   endtask

   task automatic run_until_acc(input string tag, input int target);
      for (int i = 0; i < 3000 && acc_cnt < target; i++) step();
      check(tag, 32'(acc_cnt), 32'(target));
   endtask

   task automatic wait_busy(input string tag);
      for (int i = 0; i < 3000 && !busy; i++) step();
      check(tag, 32'(busy), 32'd1);
   endtask

   task automatic wait_cfg_hs(input string tag);
      for (int i = 0; i < 100 && cfg_tvalid; i++) step();
      check(tag, 32'(cfg_tvalid), 32'd0);
   endtask

   task automatic wait_applied(input string tag, output int sr_cycles);
      sr_cycles = 0;
      for (int i = 0; i < 200 && !limit_applied; i++) begin
         if (cnt_sync_reset) sr_cycles++;
         step();
      end
      check(tag, 32'(limit_applied), 32'd1);
   endtask

   initial begin
      int sr;
      int first;
      int base;
      int b;
      int n;
      logic seen_la;
      logic seen_busy;
      logic rdy_seen;

      sync_reset_n  = 1'b0;
      cfg_tvalid    = 1'b0;
      cfg_tdata     = 16'd0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hA5A5_0001;
      c_axis_tready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_cnt_sync_reset", 32'(cnt_sync_reset), 32'd1);
      check("rst_s_tready", 32'(s_axis_tready), 32'd0);
      check("rst_c_tvalid", 32'(c_axis_tvalid), 32'd0);
      check("rst_cfg_tready", 32'(cfg_tready), 32'd0);
      check("rst_cnt_limit", 32'(cnt_limit), 32'd255);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_limit_applied", 32'(limit_applied), 32'd0);
      check("rst_mon_err", 32'(mon_err), 32'd0);

      // Release: two cycles of counter reset, first accept in cycle 3
      sync_reset_n = 1'b1;
      sr = 0;
      first = 0;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         #1;
         if (cnt_sync_reset) sr++;
         if (first == 0 && s_axis_tready && s_axis_tvalid) first = cyc;
         step();
      end
      check("release_rst_cycles", 32'(sr), 32'd2);
      check("first_accept_cycle", 32'(first), 32'd3);
      check("data_pass", c_axis_tdata, 32'hA5A5_0001);

      // Two default 256-beat frames with no config
      seen_la = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 2000 && acc_cnt < 512; i++) begin
         step();
         if (limit_applied) seen_la = 1'b1;
         if (busy) seen_busy = 1'b1;
      end
      check("default_frames_acc", 32'(acc_cnt), 32'd512);
      check("default_no_limit_applied", 32'(seen_la), 32'd0);
      check("default_no_busy", 32'(seen_busy), 32'd0);
      check("default_mon_err", 32'(mon_err), 32'd0);

      // Limit 3 requested at beat 100 of the third frame
      run_until_acc("t3_reach_beat99", 611);
      check("t3_cfg_tready", 32'(cfg_tready), 32'd1);
      cfg_tdata  = 16'd3;
      cfg_tvalid = 1'b1;
      wait_busy("t3_busy_timeout");
      check("t3_frame_completes", 32'(acc_cnt), 32'd768);
      check("t3_drain_gates_tready", 32'(s_axis_tready), 32'd0);
      wait_applied("t3_applied_timeout", sr);
      check("t3_apply_rst_cycles", 32'(sr), 32'd2);
      check("t3_cnt_limit", 32'(cnt_limit), 32'd3);
      base = acc_cnt;
      step();
      check("t3_pulse_width", 32'(limit_applied), 32'd0);
      check("t3_mon_err", 32'(mon_err), 32'd0);

      // Config handshake on the boundary beat is deferred by one full 4-beat frame
      run_until_acc("t4_reach_beat3", base + 3);
      check("t4_cfg_tready", 32'(cfg_tready), 32'd1);
      cfg_tdata  = 16'd4;
      cfg_tvalid = 1'b1;
      step();
      cfg_tdata  = 16'd9;
      cfg_tvalid = 1'b1;
      rdy_seen = 1'b0;
      for (int i = 0; i < 100 && !busy; i++) begin
         if (cfg_tready) rdy_seen = 1'b1;
         step();
      end
      check("t4_second_cfg_blocked", 32'(rdy_seen), 32'd0);
      check("t4_deferred_frame", 32'(acc_cnt), 32'(base + 8));
      cfg_tvalid = 1'b0;
      wait_applied("t4_applied_timeout", sr);
      check("t4_cnt_limit", 32'(cnt_limit), 32'd4);
      check("t4_cfg_tready_after", 32'(cfg_tready), 32'd1);

      // Downstream stall: ten beats in flight keep the scheduler in DRAIN
      base = acc_cnt;
      mon_rdy = 1'b0;
      run_until_acc("t5_reach_beat5", base + 5);
      cfg_tdata  = 16'd0;
      cfg_tvalid = 1'b1;
      wait_busy("t5_busy_timeout");
      check("t5_two_frames", 32'(acc_cnt), 32'(base + 10));
      repeat (20) step();
      check("t5_still_busy", 32'(busy), 32'd1);
      check("t5_still_drain", 32'(cnt_sync_reset), 32'd0);
      check("t5_tready_gated", 32'(s_axis_tready), 32'd0);
      mon_rdy = 1'b1;
      n = 0;
      for (int i = 0; i < 100 && !cnt_sync_reset; i++) begin
         if (mon_tvalid && mon_tready) n++;
         step();
      end
      check("t5_mon_beats_to_exit", 32'(n), 32'd10);
      wait_applied("t5_applied_timeout", sr);
      check("t5_cnt_limit", 32'(cnt_limit), 32'd0);
      check("t5_mon_err", 32'(mon_err), 32'd0);

      // Limit 0: every accept is a boundary, no drain without a pending config
      base = acc_cnt;
      run_until_acc("t6_single_beats", base + 3);
      check("t6_stays_run", 32'(busy), 32'd0);
      s_axis_tvalid = 1'b0;
      cfg_tdata  = 16'd1;
      cfg_tvalid = 1'b1;
      wait_cfg_hs("t6_cfg1_hs");
      b = acc_cnt;
      s_axis_tvalid = 1'b1;
      wait_busy("t6_busy1_timeout");
      check("t6_one_beat_drain", 32'(acc_cnt), 32'(b + 1));
      wait_applied("t6_applied1_timeout", sr);
      s_axis_tvalid = 1'b0;
      check("t6_cnt_limit1", 32'(cnt_limit), 32'd1);
      cfg_tdata  = 16'd2;
      cfg_tvalid = 1'b1;
      wait_cfg_hs("t6_cfg2_hs");
      b = acc_cnt;
      s_axis_tvalid = 1'b1;
      wait_busy("t6_busy2_timeout");
      check("t6_two_beat_frame", 32'(acc_cnt), 32'(b + 2));
      wait_applied("t6_applied2_timeout", sr);
      check("t6_cnt_limit2", 32'(cnt_limit), 32'd2);
      check("t6_mon_err", 32'(mon_err), 32'd0);

      // Reset asserted while draining abandons in-flight beats and the pending config
      mon_rdy = 1'b0;
      s_axis_tvalid = 1'b0;
      cfg_tdata  = 16'd5;
      cfg_tvalid = 1'b1;
      wait_cfg_hs("t7_cfg_hs");
      s_axis_tvalid = 1'b1;
      wait_busy("t7_busy_timeout");
      sync_reset_n = 1'b0;
      #1;
      check("t7_rst_cnt_sync_reset", 32'(cnt_sync_reset), 32'd1);
      check("t7_rst_cfg_tready", 32'(cfg_tready), 32'd0);
      check("t7_rst_s_tready", 32'(s_axis_tready), 32'd0);
      step();
      sync_reset_n = 1'b1;
      s_axis_tvalid = 1'b0;
      #1;
      check("t7_state_rst", 32'(busy), 32'd1);
      check("t7_state_rst_sync", 32'(cnt_sync_reset), 32'd1);
      check("t7_cnt_limit", 32'(cnt_limit), 32'd255);
      check("t7_mon_err_clear", 32'(mon_err), 32'd0);
      check("t7_cfg_tready_in_rst", 32'(cfg_tready), 32'd0);
      step();
      step();
      check("t7_back_to_run", 32'(busy), 32'd0);
      check("t7_pending_lost", 32'(cfg_tready), 32'd1);
      mon_rdy = 1'b1;
      force_mon = 1'b1;
      step();
      force_mon = 1'b0;
      check("t7_underflow_sets_err", 32'(mon_err), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_cycle_sched.md
Name: count_cycle_sched

Overview:
- Frame-length scheduler placed in front of a count_cycle_cw16_8 instance. It owns that instance's cnt_limit and its sync_reset.
- Accepts new frame lengths on a config stream. Each new length is applied only at an input frame boundary, after the counter pipeline and FIFO have fully drained.
- The counter therefore never sees cnt_limit change mid-frame, and every frame is exactly limit+1 beats long.

Parameters:
- DATA_WIDTH, 32, width of the pass-through data path.
- DEFAULT_LIMIT, 16'd255, cnt_limit applied after reset (frame = 256 beats).
- RST_CYCLES, 2, number of cycles cnt_sync_reset is held in RST and APPLY; must be at least 1.
- OUTS_WIDTH, 5, width of the in-flight beat counter; must cover FIFO depth 8 plus 2 pipeline stages.

Ports:
- clk  in  1  clock.
- sync_reset_n  in  1  reset; one clock, reset is synchronous, active-low.
- cfg_tvalid  in  1  new limit valid.
- cfg_tdata  in  16  new cnt_limit; frame length = value+1.
- cfg_tready  out  1  staging register free.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tdata  in  DATA_WIDTH  upstream data.
- s_axis_tready  out  1  upstream ready.
- c_axis_tvalid  out  1  to counter s_axis_tvalid.
- c_axis_tdata  out  DATA_WIDTH  to counter s_axis_tdata.
- c_axis_tready  in  1  from counter s_axis_tready.
- cnt_limit  out  16  to counter cnt_limit.
- cnt_sync_reset  out  1  active-high reset to counter.
- mon_tvalid  in  1  tap of counter m_axis_tvalid.
- mon_tready  in  1  tap of counter m_axis_tready.
- mon_final_cnt  in  1  tap of counter m_axis_final_cnt.
- limit_applied  out  1  one-cycle pulse when a new limit takes effect.
- busy  out  1  high in any state other than RUN.
- mon_err  out  1  sticky error flag.

Behaviour:
- Reset (sync_reset_n=0 at a clock edge):
  - state=RST, rst_cnt=RST_CYCLES-1, cnt_limit=DEFAULT_LIMIT, pending=0, outstanding=0, beat_cnt=DEFAULT_LIMIT.
  - limit_applied=0, mon_err=0.
  - cnt_sync_reset is combinationally 1 while sync_reset_n=0, or while state is RST or APPLY.
  - s_axis_tready=0, c_axis_tvalid=0, cfg_tready=0 while in reset.
- Reset mid-operation: in-flight beats are abandoned and the counter is reset with them; the pending config is lost.
- States:
  - RST: hold for RST_CYCLES cycles, then go to RUN. No limit_applied pulse.
  - RUN: pass-through enabled.
    - c_axis_tvalid = s_axis_tvalid; s_axis_tready = c_axis_tready; c_axis_tdata = s_axis_tdata.
    - The pass-through is combinational, zero latency.
  - DRAIN: pass-through gated; c_axis_tvalid=0, s_axis_tready=0. Wait until outstanding==0, then go to APPLY.
  - APPLY:
    - First cycle: cnt_limit<=pending_val, pending<=0.
    - Hold RST_CYCLES cycles (counter reloads its masks under reset).
    - Then go to RUN with beat_cnt=cnt_limit; limit_applied=1 for the first RUN cycle only.
- Beat counting in RUN (accept = c_axis_tvalid & c_axis_tready):
  - beat_cnt decrements per accept.
  - On an accept with beat_cnt==0: frame boundary; beat_cnt reloads to cnt_limit.
  - Boundary with pending=1: next state DRAIN, so no further beat is accepted.
  - Boundary with pending=0: stay in RUN.
- Config stream:
  - cfg_tready = ~pending & (state != RST) & sync_reset_n.
  - On a cfg handshake: pending<=1, pending_val<=cfg_tdata.
  - A config accepted in the same cycle as a boundary beat is not seen by that boundary (pending is registered); it applies at the next boundary.
  - A second config is back-pressured until APPLY clears pending.
- Outstanding counter:
  - +1 per accept, -1 per mon_tvalid&mon_tready; both in the same cycle leaves it unchanged.
  - Mon handshake with outstanding==0: counter saturates at 0 and mon_err is set.
  - Increment at all-ones: saturates and mon_err is set.
  - mon_err clears only on reset.
- DRAIN exit requires outstanding==0 and no accept in that cycle (guaranteed by gating).
- mon_final_cnt check: the last mon beat observed in DRAIN must have mon_final_cnt=1; otherwise set mon_err.
- cfg_tdata=0 is legal: frame = 1 beat, and every accept is a boundary.
- busy = (state != RUN).

Decomposition:
- count_cycle_sched_pkg holds:
  - state enum {RST, RUN, DRAIN, APPLY}, encoded 2 bits.
  - CNT_W=16.
  - OUTS_MAX derived from OUTS_WIDTH.
- No sub-module required. The outstanding up/down counter may be split out as sat_updown_cnt if reused.

Test Plan:
- Reset release, DEFAULT_LIMIT=255, continuous valid, c_axis_tready=1:
  - cnt_sync_reset high 2 cycles after release; first accept in cycle 3.
  - Boundary every 256 accepts; no limit_applied.
- cfg_tdata=3 sent mid-frame at beat 100:
  - Current frame completes 256 beats; tready low during DRAIN until outstanding reaches 0.
  - cnt_sync_reset 2 cycles; limit_applied pulse; cnt_limit=3.
  - Subsequent frames are 4 beats, with mon_final_cnt on every 4th output.
- cfg handshake in the same cycle as the boundary beat:
  - Transition deferred one full frame.
  - A second cfg during that time sees cfg_tready=0 until APPLY.
- Downstream mon_tready held 0 for 20 cycles during DRAIN: stays in DRAIN with outstanding=10; exits 10 mon handshakes after mon_tready rises.
- cfg_tdata=0: every accept is a boundary. Then cfg=1 applies after a single-beat frame drain; frames are 2 beats.
- sync_reset_n pulled low during DRAIN:
  - Next cycle: state RST, pending=0, outstanding=0, cnt_limit=255, mon_err=0.
  - Forced mon handshake with outstanding=0 then sets mon_err=1.
